// File: rtl/ef_i2c_pkg.sv
// Shared types and constants for the EF_I2C target: FSM encoding, bus field widths,
// and the serial shift helper used by the receive path.
package ef_i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } state_t;

    function automatic logic [I2C_BYTE_W-1:0] shl_byte(input logic [I2C_BYTE_W-1:0] b,
                                                       input logic bit_in);
        return {b[I2C_BYTE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/ef_i2c_sync_filt.sv
// Two-flop synchroniser followed by a stability filter: the output only follows the pin
// once the synchronised level has differed from it for FILT consecutive clocks.
module ef_i2c_sync_filt #(
    parameter int FILT = 3
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic pin,
    output logic level
);
    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;

    // Synchronise the pin and qualify level changes by how long they persist
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            sync_r  <= 2'b11;
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], pin};
            if (sync_r[1] == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(FILT - 1)) begin
                level_r <= sync_r[1];
                cnt_r   <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/ef_i2c_target.sv
// I2C target with a DEPTH-byte register file: pointer write, burst write and burst read
// over a 7-bit address, no clock stretching, open-drain SDA drive.
module ef_i2c_target
    import ef_i2c_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int FILT  = 3
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  scl_oen_o,
    output logic                  sda_o,
    output logic                  sda_oen_o,
    output logic                  wr_stb,
    output logic [AW-1:0]         wr_addr,
    output logic [I2C_BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]         reg_raddr,
    output logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic                  busy
);
    logic scl_f_s, sda_f_s, scl_d_r, sda_d_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s, last_bit_s, we_s;

    state_t                  state_r, state_n;
    logic [2:0]              bit_cnt_r, bit_cnt_n;
    logic [I2C_BYTE_W-1:0]   shift_r, shift_n, byte_s, rd_cur_s, rd_nxt_s;
    logic [AW-1:0]           ptr_r, ptr_n, ptr_inc_s, wr_addr_r, wr_addr_n;
    logic [I2C_BYTE_W-1:0]   wr_data_r, wr_data_n;
    logic                    oen_r, oen_n, busy_r, busy_n, phase_r, phase_n;
    logic                    rw_r, rw_n, wr_stb_r, wr_stb_n;
    logic [I2C_BYTE_W-1:0]   regfile_r [DEPTH];

    ef_i2c_sync_filt #(.FILT(FILT)) u_scl_filt (.CLK(CLK), .RESETn(RESETn), .pin(scl_i), .level(scl_f_s));
    ef_i2c_sync_filt #(.FILT(FILT)) u_sda_filt (.CLK(CLK), .RESETn(RESETn), .pin(sda_i), .level(sda_f_s));

    assign scl_rise_s = scl_f_s & ~scl_d_r;
    assign scl_fall_s = ~scl_f_s & scl_d_r;
    assign start_s    = scl_f_s & scl_d_r & sda_d_r & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_d_r & ~sda_d_r & sda_f_s;
    assign last_bit_s = (bit_cnt_r == 3'd7);
    assign byte_s     = shl_byte(shift_r, sda_f_s);
    assign ptr_inc_s  = ptr_r + AW'(1);
    assign rd_cur_s   = regfile_r[ptr_r];
    assign rd_nxt_s   = regfile_r[ptr_inc_s];

    // Bus protocol: next state and datapath updates, one decision per filtered bus event
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        ptr_n     = ptr_r;
        oen_n     = oen_r;
        busy_n    = busy_r;
        phase_n   = phase_r;
        rw_n      = rw_r;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr_r;
        wr_data_n = wr_data_r;
        we_s      = 1'b0;
        if (stop_s) begin
            state_n   = ST_IDLE;
            oen_n     = 1'b1;
            busy_n    = 1'b0;
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
        end else if (start_s) begin
            state_n   = ST_ADDR;
            oen_n     = 1'b1;
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
        end else begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_n   = byte_s;
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        phase_n   = 1'b0;
                        if (!last_bit_s) begin
                            state_n = state_r;
                        end else if (state_r == ST_ADDR) begin
                            if (byte_s[7:1] == own_addr) begin
                                state_n = ST_ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = byte_s[0];
                            end else begin
                                state_n = ST_IDLE;
                                busy_n  = 1'b0;
                            end
                        end else if (state_r == ST_PTR) begin
                            ptr_n   = byte_s[AW-1:0];
                            state_n = ST_PTR_ACK;
                        end else begin
                            we_s      = 1'b1;
                            wr_stb_n  = 1'b1;
                            wr_addr_n = ptr_r;
                            wr_data_n = byte_s;
                            ptr_n     = ptr_inc_s;
                            state_n   = ST_WDATA_ACK;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                // phase 0: drive the ack at the fall ending bit 8; phase 1: release at the next fall
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (!scl_fall_s) begin
                        state_n = state_r;
                    end else if (!phase_r) begin
                        oen_n   = 1'b0;
                        phase_n = 1'b1;
                    end else begin
                        phase_n   = 1'b0;
                        bit_cnt_n = 3'd0;
                        if (state_r == ST_ADDR_ACK && rw_r) begin
                            state_n = ST_RDATA;
                            shift_n = rd_cur_s;
                            oen_n   = rd_cur_s[7];
                        end else if (state_r == ST_ADDR_ACK) begin
                            state_n = ST_PTR;
                            oen_n   = 1'b1;
                        end else begin
                            state_n = ST_WDATA;
                            oen_n   = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall_s) begin
                        shift_n = {shift_r[6:0], 1'b0};
                        oen_n   = shift_r[6];
                    end else if (scl_rise_s) begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        if (last_bit_s) begin
                            state_n = ST_RDATA_ACK;
                            phase_n = 1'b0;
                        end else begin
                            state_n = state_r;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (phase_r) begin
                            ptr_n     = ptr_inc_s;
                            shift_n   = rd_nxt_s;
                            oen_n     = rd_nxt_s[7];
                            state_n   = ST_RDATA;
                            phase_n   = 1'b0;
                            bit_cnt_n = 3'd0;
                        end else begin
                            oen_n = 1'b1;
                        end
                    end else if (scl_rise_s) begin
                        if (sda_f_s) begin
                            state_n = ST_IDLE;
                        end else begin
                            phase_n = 1'b1;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    oen_n   = 1'b1;
                end
            endcase
        end
    end

    // Control and bus-facing state registers
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            ptr_r     <= {AW{1'b0}};
            oen_r     <= 1'b1;
            busy_r    <= 1'b0;
            phase_r   <= 1'b0;
            rw_r      <= 1'b0;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= 8'h00;
            scl_d_r   <= 1'b1;
            sda_d_r   <= 1'b1;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            ptr_r     <= ptr_n;
            oen_r     <= oen_n;
            busy_r    <= busy_n;
            phase_r   <= phase_n;
            rw_r      <= rw_n;
            wr_stb_r  <= wr_stb_n;
            wr_addr_r <= wr_addr_n;
            wr_data_r <= wr_data_n;
            scl_d_r   <= scl_f_s;
            sda_d_r   <= sda_f_s;
        end
    end

    // Register file written from the bus
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regfile_r[i] <= 8'h00;
            end
        end else if (we_s) begin
            regfile_r[ptr_r] <= byte_s;
        end
    end

    assign reg_rdata = regfile_r[reg_raddr];
    assign scl_o     = 1'b1;
    assign scl_oen_o = 1'b1;
    assign sda_o     = 1'b0;
    assign sda_oen_o = oen_r;
    assign wr_stb    = wr_stb_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ef_i2c_target.sv
// Directed bench for ef_i2c_target: a bit-level I2C controller model on a wired-AND bus,
// with scoreboard queues for bus writes (wr_stb) and bus reads.
module tb_ef_i2c_target;
    localparam int Q = 10;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [6:0]  own_addr = 7'h42;
    logic        scl_m, sda_m, scl_line, sda_line;
    logic        scl_o, scl_oen_o, sda_o, sda_oen_o, wr_stb, busy;
    logic [3:0]  wr_addr, reg_raddr;
    logic [7:0]  wr_data, reg_rdata;

    int          checks = 0;
    int          errors = 0;
    int          oen_low_cnt = 0;
    logic [11:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  mem_m [16];
    logic [3:0]  mptr;

    always #5 CLK = ~CLK;

    assign scl_line = scl_m & (scl_oen_o | scl_o);
    assign sda_line = sda_m & (sda_oen_o | sda_o);

    ef_i2c_target dut (
        .CLK(CLK), .RESETn(RESETn), .own_addr(own_addr),
        .scl_i(scl_line), .sda_i(sda_line),
        .scl_o(scl_o), .scl_oen_o(scl_oen_o), .sda_o(sda_o), .sda_oen_o(sda_oen_o),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write-strobe scoreboard and SDA-drive activity monitor
    always @(negedge CLK) begin
        logic [11:0] e;
        if (!sda_oen_o) oen_low_cnt++;
        if (RESETn && wr_stb) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_stb_unexpected", 32'(wr_stb), 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_stb_addr_data", {20'h0, wr_addr, wr_data}, {20'h0, e});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic qwait();
        repeat (Q) @(negedge CLK);
    endtask

    task automatic bus_bit(input logic b, input bit glitch, output logic smp);
        sda_m = b;
        if (glitch) begin
            repeat (Q / 2) @(negedge CLK);
            scl_m = 1'b1;
            @(negedge CLK);
            scl_m = 1'b0;
            repeat (Q / 2 - 1) @(negedge CLK);
        end else begin
            qwait();
        end
        scl_m = 1'b1;
        qwait();
        smp   = sda_line;
        scl_m = 1'b0;
        qwait();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic wr_byte(input logic [7:0] d, input string tag, input logic exp_ack_lvl, input int glitch_bit);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == glitch_bit), s);
        bus_bit(1'b1, 1'b0, s);
        check(tag, 32'(s), 32'(exp_ack_lvl));
    endtask

    task automatic do_ptr(input logic [7:0] p);
        wr_byte(p, "ptr_ack", 1'b0, -1);
        mptr = p[3:0];
    endtask

    task automatic do_write(input logic [7:0] d, input int glitch_bit);
        exp_wr_q.push_back({mptr, d});
        mem_m[mptr] = d;
        mptr = mptr + 4'd1;
        wr_byte(d, "wdata_ack", 1'b0, glitch_bit);
    endtask

    task automatic do_read(input bit ack, input string tag);
        logic [7:0] d;
        logic [7:0] e;
        logic       s;
        exp_rd_q.push_back(mem_m[mptr]);
        if (ack) mptr = mptr + 4'd1;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        bus_bit(ack ? 1'b0 : 1'b1, 1'b0, s);
        e = exp_rd_q.pop_front();
        check(tag, 32'(d), 32'(e));
    endtask

    task automatic chk_reg(input logic [3:0] idx, input string tag);
        reg_raddr = idx;
        #1;
        check(tag, 32'(reg_rdata), 32'(mem_m[idx]));
    endtask

    initial begin
        int n0;
        logic s;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        mptr = 4'd0; reg_raddr = 4'd0;
        scl_m = 1'b1; sda_m = 1'b1; RESETn = 1'b0;
        repeat (5) @(negedge CLK);
        check("rst_sda_oen", 32'(sda_oen_o), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_consts", {29'h0, scl_o, scl_oen_o, sda_o}, 32'h6);
        chk_reg(4'd0, "rst_reg0");
        RESETn = 1'b1;
        repeat (10) @(negedge CLK);

        // 1: pointer write then two data bytes
        bus_start();
        wr_byte(8'h84, "t1_addr_ack", 1'b0, -1);
        check("t1_busy", 32'(busy), 32'd1);
        do_ptr(8'h05);
        do_write(8'hA5, -1);
        do_write(8'h5A, -1);
        bus_stop();
        check("t1_busy_after_stop", 32'(busy), 32'd0);
        chk_reg(4'd5, "t1_reg5");
        chk_reg(4'd6, "t1_reg6");

        // 2: set pointer, repeated start, read two bytes
        bus_start();
        wr_byte(8'h84, "t2_addr_ack", 1'b0, -1);
        do_ptr(8'h05);
        bus_rstart();
        wr_byte(8'h85, "t2_addr_r_ack", 1'b0, -1);
        do_read(1'b1, "t2_read0");
        do_read(1'b0, "t2_read1");
        bus_stop();
        check("t2_busy_after_stop", 32'(busy), 32'd0);

        // 3: foreign address is ignored
        n0 = oen_low_cnt;
        bus_start();
        wr_byte(8'h86, "t3_addr_nack", 1'b1, -1);
        check("t3_busy", 32'(busy), 32'd0);
        bus_stop();
        check("t3_sda_never_driven", 32'(oen_low_cnt - n0), 32'd0);

        // 4: pointer wrap on write and read
        bus_start();
        wr_byte(8'h84, "t4_addr_ack", 1'b0, -1);
        do_ptr(8'h0F);
        do_write(8'h11, -1);
        do_write(8'h22, -1);
        bus_stop();
        chk_reg(4'd15, "t4_reg15");
        chk_reg(4'd0, "t4_reg0");
        bus_start();
        wr_byte(8'h84, "t4_addr_ack2", 1'b0, -1);
        do_ptr(8'h0F);
        bus_rstart();
        wr_byte(8'h85, "t4_addr_r_ack", 1'b0, -1);
        do_read(1'b1, "t4_read15");
        do_read(1'b0, "t4_read0_wrap");
        bus_stop();

        // 5: STOP in the middle of a data byte discards it
        bus_start();
        wr_byte(8'h84, "t5_addr_ack", 1'b0, -1);
        do_ptr(8'h03);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0, s);
        bus_stop();
        check("t5_busy", 32'(busy), 32'd0);
        chk_reg(4'd3, "t5_reg3_unchanged");
        bus_start();
        wr_byte(8'h84, "t5_next_addr_ack", 1'b0, -1);
        do_ptr(8'h03);
        do_write(8'h77, -1);
        bus_stop();
        chk_reg(4'd3, "t5_reg3_written");

        // 6a: short SCL glitch inside a data byte is filtered out
        bus_start();
        wr_byte(8'h84, "t6_addr_ack", 1'b0, -1);
        do_ptr(8'h07);
        do_write(8'h3C, 2);
        bus_stop();
        chk_reg(4'd7, "t6_reg7_glitch");

        // 6b: reset while the target drives a read bit
        bus_start();
        wr_byte(8'h84, "t6_addr_ack2", 1'b0, -1);
        do_ptr(8'h08);
        bus_rstart();
        wr_byte(8'h85, "t6_addr_r_ack", 1'b0, -1);
        check("t6_driving_bit7", 32'(sda_oen_o), 32'd0);
        RESETn = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("t6_rst_sda_released", 32'(sda_oen_o), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_wr_stb", 32'(wr_stb), 32'd0);
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        mptr = 4'd0;
        chk_reg(4'd7, "t6_rst_reg7");
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (10) @(negedge CLK);
        RESETn = 1'b1;
        repeat (10) @(negedge CLK);
        bus_start();
        wr_byte(8'h84, "t6_post_rst_addr_ack", 1'b0, -1);
        do_ptr(8'h02);
        do_write(8'h99, -1);
        bus_stop();
        chk_reg(4'd2, "t6_post_rst_reg2");

        repeat (5) @(negedge CLK);
        check("wr_stb_missing", 32'(exp_wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
